// File: rtl/conv_serializer_pkg.sv
// Shared CNN package: derived widths and the serializer FSM encoding.
package conv_serializer_pkg;

   // Serializer control states
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } ser_state_t;

   // Width of one upstream conv channel: output sample bits plus accumulator growth
   function automatic int unsigned in_bits(input int unsigned data_bits,
                                           input int unsigned filter_size);
      return data_bits + filter_size;
   endfunction

   // Index width for a count of n items, never narrower than one bit
   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags; push on full succeeds
// only when a pop happens in the same cycle.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [WIDTH-1:0]           i_data,
   output logic [WIDTH-1:0]           o_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned CNT_W = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CNT_W-1:0] r_count;
   logic             r_full;
   logic             r_empty;

   logic             w_do_push;
   logic             w_do_pop;
   logic [CNT_W-1:0] w_count_nxt;

   assign w_do_pop  = i_pop && !r_empty;
   assign w_do_push = i_push && (!r_full || w_do_pop);

   // Occupancy after this cycle's push/pop
   always_comb begin
      w_count_nxt = r_count;
      case ({w_do_push, w_do_pop})
         2'b10:   w_count_nxt = r_count + CNT_W'(1);
         2'b01:   w_count_nxt = r_count - CNT_W'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   // Storage array; contents need no reset since reads are qualified by empty
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wptr] <= i_data;
      end
   end

   // Pointers, occupancy and status flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         if (w_do_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CNT_W'(DEPTH));
         r_empty <= (w_count_nxt == '0);
      end
   end

   assign o_data  = r_mem[r_rptr];
   assign o_full  = r_full;
   assign o_empty = r_empty;
   assign o_count = r_count;

endmodule

// File: rtl/conv_serializer.sv
// Buffers multi-channel conv pixels and streams them out one channel per
// handshake, applying ReLU and saturation, with frame-end marking.
module conv_serializer
   import conv_serializer_pkg::*;
#(
   parameter int unsigned CHANNEL_LEN = 3,
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned FILTER_SIZE = 5,
   parameter int unsigned OUT_W       = 24,
   parameter int unsigned OUT_H       = 24,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic                                                  clk,
   input  logic                                                  rst,
   input  logic                                                  in_val,
   input  logic [CHANNEL_LEN*in_bits(DATA_BITS, FILTER_SIZE)-1:0] data_in,
   input  logic                                                  out_rdy,
   output logic                                                  out_val,
   output logic [DATA_BITS-1:0]                                  data_out,
   output logic [idx_width(CHANNEL_LEN)-1:0]                     out_ch,
   output logic                                                  out_last,
   output logic                                                  overflow
);

   localparam int unsigned IN_BITS = in_bits(DATA_BITS, FILTER_SIZE);
   localparam int unsigned WORD_W  = CHANNEL_LEN * IN_BITS;
   localparam int unsigned CH_W    = idx_width(CHANNEL_LEN);
   localparam int unsigned COL_W   = idx_width(OUT_W);
   localparam int unsigned ROW_W   = idx_width(OUT_H);
   localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

   localparam logic [CH_W-1:0]    LAST_CH  = CH_W'(CHANNEL_LEN - 1);
   localparam logic [COL_W-1:0]   LAST_COL = COL_W'(OUT_W - 1);
   localparam logic [ROW_W-1:0]   LAST_ROW = ROW_W'(OUT_H - 1);
   localparam logic [IN_BITS-1:0] SAT_MAX  = IN_BITS'((1 << DATA_BITS) - 1);

   ser_state_t        r_state;
   ser_state_t        w_state_nxt;
   logic [CH_W-1:0]   r_ch;
   logic [CH_W-1:0]   w_ch_nxt;
   logic [COL_W-1:0]  r_col;
   logic [COL_W-1:0]  w_col_nxt;
   logic [ROW_W-1:0]  r_row;
   logic [ROW_W-1:0]  w_row_nxt;
   logic              r_overflow;

   logic              w_xfer;
   logic              w_pop;
   logic              w_push;
   logic              w_full;
   logic              w_empty;
   logic [CNT_W-1:0]  w_count;
   logic              w_last_word;
   logic [WORD_W-1:0] w_head;
   logic [IN_BITS-1:0]   w_ch_raw;
   logic [DATA_BITS-1:0] w_ch_conv;

   // Handshake decode: a word leaves the FIFO when its final channel transfers
   assign w_xfer      = out_val && out_rdy;
   assign w_pop       = w_xfer && (r_ch == LAST_CH);
   assign w_push      = in_val && (!w_full || w_pop);
   assign w_last_word = (w_count == CNT_W'(1)) && !w_push;

   // Input word buffer
   sync_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (data_in),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // FSM state and channel index register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_ch    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ch    <= w_ch_nxt;
      end
   end

   // Next state: enter SEND as the first word lands, leave after the final
   // channel of the final buffered word, otherwise restart at channel 0
   always_comb begin
      w_state_nxt = r_state;
      w_ch_nxt    = r_ch;
      case (r_state)
         ST_IDLE: begin
            w_ch_nxt = '0;
            if (!w_empty || w_push) begin
               w_state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            if (w_xfer) begin
               if (r_ch == LAST_CH) begin
                  w_ch_nxt = '0;
                  if (w_last_word) begin
                     w_state_nxt = ST_IDLE;
                  end
               end else begin
                  w_ch_nxt = r_ch + CH_W'(1);
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_ch_nxt    = '0;
         end
      endcase
   end

   // Pixel position counters register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_col <= '0;
         r_row <= '0;
      end else begin
         r_col <= w_col_nxt;
         r_row <= w_row_nxt;
      end
   end

   // Raster advance: one pixel per popped word, wrapping at the frame edge
   always_comb begin
      w_col_nxt = r_col;
      w_row_nxt = r_row;
      if (w_pop) begin
         if (r_col == LAST_COL) begin
            w_col_nxt = '0;
            w_row_nxt = (r_row == LAST_ROW) ? '0 : r_row + ROW_W'(1);
         end else begin
            w_col_nxt = r_col + COL_W'(1);
         end
      end
   end

   // Sticky drop flag: a word arrived with no room and nothing leaving
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow <= 1'b0;
      end else if (in_val && w_full && !w_pop) begin
         r_overflow <= 1'b1;
      end
   end

   assign w_ch_raw = w_head[int'(r_ch) * IN_BITS +: IN_BITS];

   // ReLU then saturate the selected channel into the unsigned sample range
   always_comb begin
      w_ch_conv = w_ch_raw[DATA_BITS-1:0];
      if (w_ch_raw[IN_BITS-1]) begin
         w_ch_conv = '0;
      end else if (w_ch_raw > SAT_MAX) begin
         w_ch_conv = '1;
      end
   end

   assign out_val  = (r_state == ST_SEND);
   assign data_out = out_val ? w_ch_conv : '0;
   assign out_ch   = r_ch;
   assign out_last = out_val && (r_ch == LAST_CH) &&
                     (r_col == LAST_COL) && (r_row == LAST_ROW);
   assign overflow = r_overflow;

endmodule

// File: tb/tb_conv_serializer.sv
// Randomized and directed bench for conv_serializer against a queue-based
// reference model of the buffered channel stream.
module tb_conv_serializer;

   localparam int unsigned CH  = 3;
   localparam int unsigned DB  = 8;
   localparam int unsigned FS  = 5;
   localparam int unsigned OW  = 2;
   localparam int unsigned OH  = 2;
   localparam int unsigned FD  = 4;
   localparam int unsigned IB  = DB + FS;
   localparam int unsigned WW  = CH * IB;
   localparam int          MAXV = (1 << DB) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_val;
   logic [WW-1:0] data_in;
   logic          out_rdy;
   logic          out_val;
   logic [DB-1:0] data_out;
   logic [1:0]    out_ch;
   logic          out_last;
   logic          overflow;

   conv_serializer #(
      .CHANNEL_LEN (CH),
      .DATA_BITS   (DB),
      .FILTER_SIZE (FS),
      .OUT_W       (OW),
      .OUT_H       (OH),
      .FIFO_DEPTH  (FD)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_val   (in_val),
      .data_in  (data_in),
      .out_rdy  (out_rdy),
      .out_val  (out_val),
      .data_out (data_out),
      .out_ch   (out_ch),
      .out_last (out_last),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   // Reference model: pending words, channel within head word, pixel number
   logic [WW-1:0] m_q[$];
   int            m_ch;
   int            m_pix;
   bit            m_ovf;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int expect_sample(input logic [WW-1:0] w, input int k);
      logic [IB-1:0] f;
      int            v;
      f = w[k*IB +: IB];
      v = int'($signed(f));
      if (v < 0)    return 0;
      if (v > MAXV) return MAXV;
      return v;
   endfunction

   function automatic logic [WW-1:0] pack3(input int a, input int b, input int c);
      logic [WW-1:0] w;
      w = '0;
      w[0*IB +: IB] = IB'(a);
      w[1*IB +: IB] = IB'(b);
      w[2*IB +: IB] = IB'(c);
      return w;
   endfunction

   function automatic logic [WW-1:0] rand_word();
      int v[CH];
      int edge_vals[5];
      edge_vals = '{0, MAXV, MAXV + 1, -1, (1 << (IB - 1)) - 1};
      for (int k = 0; k < CH; k++) begin
         case ($urandom_range(0, 4))
            0:       v[k] = int'($urandom_range(0, MAXV));
            1:       v[k] = -int'($urandom_range(1, 1 << (IB - 1)));
            2:       v[k] = int'($urandom_range(MAXV + 1, (1 << (IB - 1)) - 1));
            3:       v[k] = edge_vals[$urandom_range(0, 4)];
            default: v[k] = int'($urandom);
         endcase
      end
      return pack3(v[0], v[1], v[2]);
   endfunction

   // One clock cycle: check outputs against the model, drive inputs, advance the model
   task automatic step(input bit iv, input logic [WW-1:0] d, input bit rdy);
      bit ev;
      bit pop;
      @(negedge clk);
      ev = (m_q.size() != 0);
      chk("out_val", 32'(out_val), 32'(ev));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("out_last", 32'(out_last), 32'(ev && m_ch == CH - 1 && m_pix == OW * OH - 1));
      if (ev) begin
         chk("data_out", 32'(data_out), 32'(expect_sample(m_q[0], m_ch)));
         chk("out_ch", 32'(out_ch), 32'(m_ch));
      end
      in_val  = iv;
      data_in = d;
      out_rdy = rdy;
      pop = ev && rdy && (m_ch == CH - 1);
      if (iv) begin
         if (m_q.size() < FD || pop) m_q.push_back(d);
         else                        m_ovf = 1'b1;
      end
      if (ev && rdy) begin
         if (m_ch == CH - 1) begin
            m_ch = 0;
            void'(m_q.pop_front());
            m_pix = (m_pix + 1) % (OW * OH);
         end else begin
            m_ch++;
         end
      end
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      while (m_q.size() != 0 && budget < 100) begin
         step(1'b0, '0, 1'b1);
         budget++;
      end
      step(1'b0, '0, 1'b1);
   endtask

   // Asynchronous reset: outputs must clear without waiting for a clock edge
   task automatic do_reset();
      rst     = 1'b1;
      in_val  = 1'b0;
      out_rdy = 1'b0;
      data_in = '0;
      #1;
      chk("rst_out_val", 32'(out_val), 32'(0));
      chk("rst_data_out", 32'(data_out), 32'(0));
      chk("rst_out_ch", 32'(out_ch), 32'(0));
      chk("rst_out_last", 32'(out_last), 32'(0));
      chk("rst_overflow", 32'(overflow), 32'(0));
      m_q.delete();
      m_ch  = 0;
      m_pix = 0;
      m_ovf = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst     = 1'b0;
      in_val  = 1'b0;
      out_rdy = 1'b0;
      data_in = '0;
      m_ch    = 0;
      m_pix   = 0;
      m_ovf   = 1'b0;
      #2;
      do_reset();

      // Single word with in-range, negative and oversized channels
      step(1'b1, pack3(5, -3, 300), 1'b1);
      drain();

      // Sink stalls for four cycles with a word pending
      step(1'b1, rand_word(), 1'b0);
      repeat (4) step(1'b0, '0, 1'b0);
      drain();

      // Five words into a four-deep buffer with no draining
      repeat (5) step(1'b1, rand_word(), 1'b0);
      step(1'b0, '0, 1'b0);
      drain();
      do_reset();

      // Full buffer, push lands on the popping cycle
      repeat (4) step(1'b1, rand_word(), 1'b0);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
      step(1'b1, rand_word(), 1'b1);
      drain();

      // Frame wrap on a 2x2 map over five pixels
      do_reset();
      repeat (5) step(1'b1, rand_word(), 1'b1);
      drain();

      // Reset mid-word while channel 1 is presented
      step(1'b1, rand_word(), 1'b1);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      do_reset();
      step(1'b1, rand_word(), 1'b1);
      drain();

      // Random traffic with light input load
      repeat (600) step($urandom_range(0, 99) < 22, rand_word(), $urandom_range(0, 99) < 80);
      drain();

      // Random traffic heavy enough to overflow
      do_reset();
      repeat (300) step($urandom_range(0, 99) < 60, rand_word(), $urandom_range(0, 99) < 50);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/conv_serializer.md
CONV_SERIALIZER -- requirements
Module: conv_serializer

Interface
REQ-001 SHALL have parameter CHANNEL_LEN, default 3: number of channels per input word.
REQ-002 SHALL have parameter DATA_BITS, default 8: width of each serialized output sample.
REQ-003 SHALL have parameter FILTER_SIZE, default 5: filter size of the upstream conv layer; input channel width IN_BITS = DATA_BITS+FILTER_SIZE.
REQ-004 SHALL have parameters OUT_W, default 24, and OUT_H, default 24: feature-map width and height, in pixels.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4: number of input words buffered; must be a power of two, at least 2.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port in_val, input, 1 bit: data_in carries a valid multi-channel pixel this cycle.
REQ-009 SHALL have port data_in, input, CHANNEL_LEN*IN_BITS bits: channel k occupies bits [k*IN_BITS +: IN_BITS], signed two's complement.
REQ-010 SHALL have port out_rdy, input, 1 bit: the downstream sink accepts data_out this cycle.
REQ-011 SHALL have port out_val, output, 1 bit: data_out is valid.
REQ-012 SHALL have port data_out, output, DATA_BITS bits: the converted channel sample, unsigned.
REQ-013 SHALL have port out_ch, output, clog2(CHANNEL_LEN) bits (minimum 1): channel index of data_out.
REQ-014 SHALL have port out_last, output, 1 bit: marks the last channel of the last pixel of a frame.
REQ-015 SHALL have port overflow, output, 1 bit: sticky flag, set when an input word is dropped.

Function
REQ-016 SHALL push data_in into the FIFO on every cycle with in_val=1, unless the push is dropped per REQ-024; the upstream has no backpressure.
REQ-017 SHALL emit one channel per handshake, in channel order 0..CHANNEL_LEN-1, taken from the FIFO head word.
REQ-018 SHALL complete a transfer on a cycle with out_val=1 and out_rdy=1.
REQ-019 SHALL hold data_out, out_ch and out_last stable while out_val=1 and out_rdy=0.
REQ-020 SHALL convert each channel as follows: negative -> 0 (ReLU); value greater than 2^DATA_BITS-1 -> 2^DATA_BITS-1 (saturate); otherwise the low DATA_BITS bits.
REQ-021 SHALL use FSM states IDLE and SEND: IDLE->SEND when the FIFO is non-empty; SEND->IDLE after the last channel transfer if the FIFO is then empty; otherwise stay in SEND with the channel index reset to 0.
REQ-022 SHALL assert out_val in the cycle after a push into an empty FIFO while in IDLE (latency 1); with out_rdy held high, SHALL issue back-to-back channels with no bubble between words.
REQ-023 SHALL pop the FIFO head on the transfer of channel CHANNEL_LEN-1.
REQ-024 SHALL drop data_in when in_val=1, the FIFO is full and no pop occurs in the same cycle, and set overflow; a push and pop in the same cycle on a full FIFO SHALL both succeed.
REQ-025 SHALL keep col (0..OUT_W-1) and row (0..OUT_H-1) pixel counters that advance on each pop; col wraps to 0 and increments row; row wraps to 0 after OUT_H-1.
REQ-026 SHALL assert out_last only while out_ch=CHANNEL_LEN-1, col=OUT_W-1 and row=OUT_H-1.
REQ-027 SHALL keep overflow at 1 once set, until reset.

Reset
REQ-028 SHALL, while rst=1, force out_val=0, data_out=0, out_ch=0, out_last=0, overflow=0, FIFO empty, FSM in IDLE and col=row=0.
REQ-029 SHALL discard partially serialized words on reset mid-operation; the first word after reset SHALL start at channel 0, pixel (0,0).

Structure
REQ-030 SHALL place the derived IN_BITS, the channel-index width function and the FSM state encoding in the shared CNN package.
REQ-031 SHALL implement the FIFO as one sub-module, sync_fifo, with push/pop/full/empty ports; the conversion and the FSM stay in conv_serializer.

Verification
REQ-032 Bench SHALL cover: reset; one word with channels {ch0=5, ch1=-3, ch2=300}, out_rdy=1 -> data_out 5, 0, 255 on three consecutive cycles, out_ch 0, 1, 2, first out_val one cycle after in_val.
REQ-033 Bench SHALL cover: out_rdy=0 for 4 cycles with a word pending -> out_val=1 and data_out constant throughout, then the stream completes normally.
REQ-034 Bench SHALL cover: with out_rdy=0, 5 consecutive in_val words at FIFO_DEPTH=4 -> overflow=1 on the 5th cycle, the 5th word never appears, the first 4 emerge in order.
REQ-035 Bench SHALL cover: a full FIFO with out_rdy=1 and in_val on the popping cycle -> no drop and overflow stays 0.
REQ-036 Bench SHALL cover: OUT_W=2, OUT_H=2, 5 words -> out_last only on channel 2 of word 4; word 5 starts at row=col=0 with out_last=0.
REQ-037 Bench SHALL cover: rst asserted mid-word at channel 1 -> all outputs 0 immediately; a word after release starts at channel 0.
